// File: rtl/mult_pipe_n.sv
// Pipelined WIDTH x WIDTH multiplier that retires WIDTH/STAGES multiplier bits per stage; the optional MULT_HIGH_HALF_EN macro enables 2*WIDTH signed/high-half mode.
// Latency: done is asserted STAGES cycles after the edge that sampled start.
// Backpressure: none; one operation is accepted every cycle, and flush squashes all in-flight work.
module mult_pipe_n #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 8,
    parameter int TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    input  logic             mcand_signed,
    input  logic             mplier_signed,
    input  logic             high_sel,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CH   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
`ifdef MULT_HIGH_HALF_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    typedef struct packed {
        logic             vld;
        logic             hi;
        logic [TAG_W-1:0] tag;
        logic [AW-1:0]    acc;
        logic [AW-1:0]    mc;
        logic [WIDTH-1:0] mp;
    } stage_t;

    stage_t     init;
    stage_t     stg [STAGES];
    logic [WIDTH-1:0] res;

    function automatic stage_t step(input stage_t s);
        stage_t        n;
        logic [AW-1:0] chunk;
        n            = s;
        chunk        = '0;
        chunk[CH-1:0] = s.mp[CH-1:0];
        n.acc        = s.acc + s.mc * chunk;
        n.mc         = s.mc << CH;
        n.mp         = s.mp >> CH;
        return n;
    endfunction

    // Only the low WIDTH multiplier bits are scanned; a negative signed
    // multiplier is handled by pre-loading the accumulator with -(mc << WIDTH).
    always_comb begin
        init     = '0;
        init.vld = start & ~flush;
        init.hi  = high_sel;
        init.tag = tag_in;
        init.mp  = mplier;
`ifdef MULT_HIGH_HALF_EN
        init.mc  = {{WIDTH{mcand_signed & mcand[WIDTH-1]}}, mcand};
        init.acc = (mplier_signed & mplier[WIDTH-1]) ? -(init.mc << WIDTH) : '0;
`else
        init.mc  = mcand;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) stg[s] <= '0;
        end else begin
            stg[0]     <= step(init);
            stg[0].vld <= init.vld;
            for (int s = 1; s < STAGES; s++) begin
                stg[s]     <= step(stg[s-1]);
                stg[s].vld <= stg[s-1].vld & ~flush;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) busy = busy | stg[s].vld;
    end

`ifdef MULT_HIGH_HALF_EN
    assign res = stg[LAST].hi ? stg[LAST].acc[AW-1:WIDTH] : stg[LAST].acc[WIDTH-1:0];
    logic unused_tail;
    assign unused_tail = ^{stg[LAST].mc, stg[LAST].mp};
`else
    assign res = stg[LAST].acc;
    logic unused_tail;
    assign unused_tail = ^{stg[LAST].mc, stg[LAST].mp, stg[LAST].hi,
                           mcand_signed, mplier_signed};
`endif

    // A flush on the completing edge also suppresses that completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            product <= '0;
            tag_out <= '0;
        end else begin
            done <= stg[LAST].vld & ~flush;
            if (stg[LAST].vld & ~flush) begin
                product <= res;
                tag_out <= stg[LAST].tag;
            end
        end
    end

endmodule

// File: doc/mult_pipe_n.md
MULT_PIPE_N -- requirements
Module: mult_pipe_n

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and product width in bits.
REQ-002 SHALL have parameter STAGES, default 8, number of pipeline stages (2..16); WIDTH SHALL be divisible by STAGES.
REQ-003 SHALL have parameter TAG_W, default 6, width of the sideband tag carried with each operation.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  issue a new operation this cycle.
REQ-007 SHALL have port mcand  input  WIDTH  multiplicand.
REQ-008 SHALL have port mplier  input  WIDTH  multiplier.
REQ-009 SHALL have port mcand_signed  input  1  treat mcand as two's complement.
REQ-010 SHALL have port mplier_signed  input  1  treat mplier as two's complement.
REQ-011 SHALL have port high_sel  input  1  return the upper WIDTH bits of the 2*WIDTH product.
REQ-012 SHALL have port tag_in  input  TAG_W  sideband tag, returned unmodified with the result.
REQ-013 SHALL have port flush  input  1  squash all in-flight operations.
REQ-014 SHALL have port product  output  WIDTH  result.
REQ-015 SHALL have port done  output  1  product and tag_out valid this cycle.
REQ-016 SHALL have port tag_out  output  TAG_W  tag of the completing operation.
REQ-017 SHALL have port busy  output  1  at least one stage holds a valid operation.

Function
REQ-018 SHALL be fully pipelined: one operation accepted per cycle, no stalls, no backpressure.
REQ-019 SHALL assert done exactly STAGES cycles after the rising edge at which start=1 was sampled.
REQ-020 Each stage SHALL add the partial product of WIDTH/STAGES multiplier bits to a running 2*WIDTH accumulator, carrying the shifted operands, the valid bit, tag, high_sel and signedness to the next stage.
REQ-021 Operands SHALL be sign- or zero-extended to 2*WIDTH per their signed flags; the result SHALL be bits [2*WIDTH-1:0] of the extended product.
REQ-022 product SHALL equal result[WIDTH-1:0] when high_sel=0 and result[2*WIDTH-1:WIDTH] when high_sel=1.
REQ-023 product and tag_out SHALL hold their last completed values while done=0.
REQ-024 flush=1 SHALL clear every stage valid bit at the same edge; done SHALL be 0 on the following cycle.
REQ-025 start and flush in the same cycle: the new operation SHALL be discarded.
REQ-026 busy SHALL be the OR of all stage valid bits, excluding the output register.
REQ-027 Back-to-back operations with differing modes SHALL each complete with their own mode; no cross-operation interference.

Reset
REQ-028 reset=1 SHALL asynchronously clear all stage valid bits, done, busy, product and tag_out to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; no done SHALL be produced for them after release.
REQ-030 The first start sampled after reset release SHALL complete with normal latency.

Configuration
REQ-031 Macro MULT_HIGH_HALF_EN defined: accumulator is 2*WIDTH bits, high_sel and signed flags honoured per REQ-021/REQ-022.
REQ-032 Macro MULT_HIGH_HALF_EN undefined: accumulator is WIDTH bits, high_sel, mcand_signed and mplier_signed are ignored, product = low WIDTH bits of mcand*mplier.

Verification (WIDTH=64, STAGES=8, TAG_W=6, macro defined unless noted)
REQ-033 start, mcand=3, mplier=5, high_sel=0, tag_in=0x2A -> done at cycle +8, product=15, tag_out=0x2A.
REQ-034 mcand=mplier=0xFFFF_FFFF_FFFF_FFFF, high_sel=1: unsigned -> product=0xFFFF_FFFF_FFFF_FFFE; both signed -> product=0.
REQ-035 8 consecutive starts with mcand=i+1, mplier=2, tags 0..7 -> done high 8 consecutive cycles, products 2,4,...,16 in order.
REQ-036 4 ops issued, flush on cycle 2 -> no done for any; busy=0 on next cycle; op issued after flush completes normally.
REQ-037 reset pulsed while 3 ops in flight -> done/product/tag_out/busy read 0 immediately, no late done.
REQ-038 Macro undefined: mcand=mplier=0xFFFF_FFFF_FFFF_FFFF, high_sel=1, both signed -> product=1.
